// File: rtl/adc_qsys_nios2_gen2_cpu_mul_combine_if.sv
// Purpose: bundles the multiply-combine handshake between the CPU M stage
//   (master) and the partial-product combiner (slave).
// Signals:
//   M_en, M_mul_start, M_mul_op     : pipeline enable, start strobe, op code
//   M_src1, M_src2                  : full-width operands a and b
//   M_mul_cell_p1..p3               : a_lo*b_lo, a_lo*b_hi, a_hi*b_lo
//   M_mul_stall                     : pipeline hold while a MULX op runs
//   A_mul_result, A_mul_valid       : registered result and its one-cycle strobe
interface adc_qsys_nios2_gen2_cpu_mul_combine_if #(
  parameter int HALF_W = 16
);
  localparam int W = 2 * HALF_W;

  logic         M_en;
  logic         M_mul_start;
  logic [1:0]   M_mul_op;
  logic [W-1:0] M_src1;
  logic [W-1:0] M_src2;
  logic [W-1:0] M_mul_cell_p1;
  logic [W-1:0] M_mul_cell_p2;
  logic [W-1:0] M_mul_cell_p3;
  logic         M_mul_stall;
  logic [W-1:0] A_mul_result;
  logic         A_mul_valid;

  modport master (
    output M_en, M_mul_start, M_mul_op, M_src1, M_src2,
           M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    input  M_mul_stall, A_mul_result, A_mul_valid
  );

  modport slave (
    input  M_en, M_mul_start, M_mul_op, M_src1, M_src2,
           M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    output M_mul_stall, A_mul_result, A_mul_valid
  );
endinterface

// File: rtl/adc_qsys_nios2_gen2_cpu_mul_combine.sv
// Purpose: combines the three registered half-width partial products into the
//   low-word MUL result in one cycle; for MULX ops computes the missing
//   hi*hi product with a shift-add loop, applies signed corrections to the
//   high word and stalls the pipeline until done.
// Ports:
//   clk    : core clock
//   reset  : asynchronous, active-high reset
//   bus    : slave side of the combine interface (see interface header)
//
// state  | meaning
// S_IDLE | waiting for an accepted start; MUL completes directly from here
// S_MULHH| accumulating a_hi*b_hi, BITS_PER_ITER multiplier bits per cycle
// S_FIX  | forming the high word and applying signed corrections
module adc_qsys_nios2_gen2_cpu_mul_combine #(
  parameter int HALF_W        = 16,
  parameter int BITS_PER_ITER = 1
) (
  input  logic clk,
  input  logic reset,
  adc_qsys_nios2_gen2_cpu_mul_combine_if.slave bus
);
  localparam int W  = 2 * HALF_W;
  localparam int N  = HALF_W / BITS_PER_ITER;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MULHH, S_FIX} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  a_q, b_q, p1_q;
  logic [W:0]    mid_q;
  logic [1:0]    op_q;
  logic [W-1:0]  result_q;
  logic          valid_q;

  logic          accept;
  logic [W:0]    mid_in;
  logic [W-1:0]  mul_lo;
  logic [2*W-1:0] full_prod;
  logic [W-1:0]  fix_res;

  // Reset gating keeps the stall low while reset is held even if start is up.
  assign accept = bus.M_mul_start & bus.M_en & (state_q == S_IDLE) & ~reset;

  assign mid_in = {1'b0, bus.M_mul_cell_p2} + {1'b0, bus.M_mul_cell_p3};
  // Only the low word is needed for MUL, so mid's upper half and hh drop out.
  assign mul_lo = bus.M_mul_cell_p1 + {mid_in[HALF_W-1:0], {HALF_W{1'b0}}};

  // One shift-add step: multiplier bits of a_hi at the current counter
  // position times b_hi, aligned to that position.
  always_comb begin
    logic [BITS_PER_ITER-1:0] a_bits;
    logic [W-1:0]             b_hi_ext;
    logic [W-1:0]             step;
    int                       sh;
    sh       = int'(cnt_q) * BITS_PER_ITER;
    a_bits   = a_q[HALF_W + sh +: BITS_PER_ITER];
    b_hi_ext = {{HALF_W{1'b0}}, b_q[W-1:HALF_W]};
    step     = (b_hi_ext * W'(a_bits)) << sh;
    acc_d    = acc_q + step;
  end

  assign full_prod = {acc_q, {W{1'b0}}}
                   + {{(HALF_W-1){1'b0}}, mid_q, {HALF_W{1'b0}}}
                   + {{W{1'b0}}, p1_q};

  // Unsigned high word minus the two's-complement corrections, mod 2^W.
  always_comb begin
    logic [W-1:0] corr_a, corr_b;
    corr_a  = (op_q[1] && a_q[W-1]) ? b_q : '0;
    corr_b  = (op_q == 2'b11 && b_q[W-1]) ? a_q : '0;
    fix_res = full_prod[2*W-1:W] - corr_a - corr_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p1_q     <= '0;
      mid_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (bus.M_mul_op == 2'b00) begin
              result_q <= mul_lo;
              valid_q  <= 1'b1;
            end else begin
              a_q     <= bus.M_src1;
              b_q     <= bus.M_src2;
              p1_q    <= bus.M_mul_cell_p1;
              mid_q   <= mid_in;
              op_q    <= bus.M_mul_op;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_MULHH;
            end
          end
        end
        S_MULHH: begin
          acc_q <= acc_d;
          if (cnt_q == CW'(N - 1)) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIX: begin
          result_q <= fix_res;
          valid_q  <= 1'b1;
          cnt_q    <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.M_mul_stall  = (accept && bus.M_mul_op != 2'b00) || (state_q != S_IDLE);
  assign bus.A_mul_result = result_q;
  assign bus.A_mul_valid  = valid_q;
endmodule

// File: tb/tb_adc_qsys_nios2_gen2_cpu_mul_combine.sv
module tb_adc_qsys_nios2_gen2_cpu_mul_combine;
  logic        clk = 1'b0;
  logic        reset;
  logic        en, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [31:0] p1, p2, p3;
  int          target;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign p1 = {16'b0, a[15:0]}  * {16'b0, b[15:0]};
  assign p2 = {16'b0, a[15:0]}  * {16'b0, b[31:16]};
  assign p3 = {16'b0, a[31:16]} * {16'b0, b[15:0]};

  adc_qsys_nios2_gen2_cpu_mul_combine_if #(.HALF_W(16)) bus1 ();
  adc_qsys_nios2_gen2_cpu_mul_combine_if #(.HALF_W(16)) bus2 ();

  assign bus1.M_en = en;
  assign bus1.M_mul_start = start & (target == 0);
  assign bus1.M_mul_op = op;
  assign bus1.M_src1 = a;
  assign bus1.M_src2 = b;
  assign bus1.M_mul_cell_p1 = p1;
  assign bus1.M_mul_cell_p2 = p2;
  assign bus1.M_mul_cell_p3 = p3;

  assign bus2.M_en = en;
  assign bus2.M_mul_start = start & (target == 1);
  assign bus2.M_mul_op = op;
  assign bus2.M_src1 = a;
  assign bus2.M_src2 = b;
  assign bus2.M_mul_cell_p1 = p1;
  assign bus2.M_mul_cell_p2 = p2;
  assign bus2.M_mul_cell_p3 = p3;

  adc_qsys_nios2_gen2_cpu_mul_combine #(.HALF_W(16), .BITS_PER_ITER(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  adc_qsys_nios2_gen2_cpu_mul_combine #(.HALF_W(16), .BITS_PER_ITER(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  logic        o_stall, o_valid;
  logic [31:0] o_result;
  assign o_stall  = (target == 0) ? bus1.M_mul_stall  : bus2.M_mul_stall;
  assign o_valid  = (target == 0) ? bus1.A_mul_valid  : bus2.A_mul_valid;
  assign o_result = (target == 0) ? bus1.A_mul_result : bus2.A_mul_result;

  function automatic logic [31:0] golden(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [65:0] ex, ey, pr;
    ex = {{34{o[1] & x[31]}}, x};
    ey = {{34{(o == 2'b11) & y[31]}}, y};
    pr = ex * ey;
    return (o == 2'b00) ? pr[31:0] : pr[63:32];
  endfunction

  // Issues one op at cycle 0 and checks stall/valid/result cycle by cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] exp, input string nm);
    int lat;
    lat = (o == 2'b00) ? 1 : ((target == 0) ? 18 : 10);
    @(posedge clk); #1;
    en = 1'b1; start = 1'b1; op = o; a = aa; b = bb;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_stall !== (c < lat && o != 2'b00)) begin
        n_err++;
        $display("FAIL %s stall c=%0d got=%b exp=%b", nm, c, o_stall, (c < lat && o != 2'b00));
      end
      n_cmp++;
      if (o_valid !== (c == lat)) begin
        n_err++;
        $display("FAIL %s valid c=%0d got=%b exp=%b", nm, c, o_valid, (c == lat));
      end
      if (c == lat) begin
        n_cmp++;
        if (o_result !== exp) begin
          n_err++;
          $display("FAIL %s result got=%h exp=%h", nm, o_result, exp);
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      a = ~aa; b = bb ^ 32'h5A5A_A5A5;
    end
    @(negedge clk);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s valid_after got=%b exp=0", nm, o_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; target = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus1.M_mul_stall !== 1'b0 || bus1.A_mul_valid !== 1'b0 || bus1.A_mul_result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_dut1 got=%b/%b/%h exp=0/0/0", bus1.M_mul_stall, bus1.A_mul_valid, bus1.A_mul_result);
    end
    n_cmp++;
    if (bus2.M_mul_stall !== 1'b0 || bus2.A_mul_valid !== 1'b0 || bus2.A_mul_result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_dut2 got=%b/%b/%h exp=0/0/0", bus2.M_mul_stall, bus2.A_mul_valid, bus2.A_mul_result);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_vectors(input int tgt);
    target = tgt;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "ones_mul");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "ones_mulxuu");
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones_mulxsu");
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "ones_mulxss");
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "hi1_mul");
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "hi1_mulxuu");
    run_op(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "min_mulxss");
    run_op(2'b10, 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, "min_mulxsu");
  endtask

  task automatic test_mul_en_toggle();
    logic        exp_v [5];
    logic [31:0] exp_r [5];
    exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_r = '{32'h0, 32'd15, 32'd15, 32'h0003_0000, 32'h0003_0000};
    target = 0;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; en = 1'b1; a = 32'd3; b = 32'd5;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_valid !== exp_v[c]) begin
        n_err++;
        $display("FAIL en_toggle valid c=%0d got=%b exp=%b", c, o_valid, exp_v[c]);
      end
      if (c > 0) begin
        n_cmp++;
        if (o_result !== exp_r[c]) begin
          n_err++;
          $display("FAIL en_toggle result c=%0d got=%h exp=%h", c, o_result, exp_r[c]);
        end
      end
      @(posedge clk); #1;
      if (c == 0) begin en = 1'b0; a = 32'd7; b = 32'd9; end
      else if (c == 1) begin en = 1'b1; a = 32'h0001_0000; b = 32'h0001_0003; end
      else begin start = 1'b0; en = 1'b1; end
    end
  endtask

  task automatic test_ignore_busy();
    target = 0;
    @(posedge clk); #1;
    en = 1'b1; start = 1'b1; op = 2'b01; a = 32'h0001_0000; b = 32'h0001_0000;
    for (int c = 0; c <= 19; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_valid !== (c == 18)) begin
        n_err++;
        $display("FAIL busy_ignore valid c=%0d got=%b exp=%b", c, o_valid, (c == 18));
      end
      if (c == 18) begin
        n_cmp++;
        if (o_result !== 32'h0000_0001) begin
          n_err++;
          $display("FAIL busy_ignore result got=%h exp=00000001", o_result);
        end
      end
      @(posedge clk); #1;
      start = (c + 1 == 5);
      if (c + 1 == 5) begin op = 2'b00; a = 32'd5; b = 32'd5; end
    end
  endtask

  task automatic test_reset_mid();
    target = 0;
    run_op(2'b00, 32'd3, 32'd5, 32'd15, "pre_reset_mul");
    @(posedge clk); #1;
    en = 1'b1; start = 1'b1; op = 2'b01; a = 32'h0001_0000; b = 32'h0001_0000;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (o_stall !== 1'b0 || o_valid !== 1'b0 || o_result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid got=%b/%b/%h exp=0/0/0", o_stall, o_valid, o_result);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (o_valid !== 1'b0 || o_stall !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_quiet c=%0d got=%b/%b exp=0/0", c, o_valid, o_stall);
      end
    end
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "post_reset_mulxuu");
  endtask

  task automatic test_random(input int tgt, input int count);
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          pk;
    target = tgt;
    for (int i = 0; i < count; i++) begin
      ro = 2'($urandom_range(0, 3));
      pk = $urandom_range(0, 7);
      ra = (pk == 0) ? 32'h8000_0000 : (pk == 1) ? 32'hFFFF_FFFF : $urandom();
      pk = $urandom_range(0, 7);
      rb = (pk == 0) ? 32'h8000_0000 : (pk == 1) ? 32'hFFFF_FFFF : $urandom();
      run_op(ro, ra, rb, golden(ro, ra, rb), "random");
    end
  endtask

  initial begin
    test_reset();
    test_vectors(0);
    test_vectors(1);
    test_mul_en_toggle();
    test_ignore_busy();
    test_reset_mid();
    test_random(0, 1000);
    test_random(1, 200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
